// File: rtl/altmemddr_local_burst_master_if.sv
// Local (Avalon-mode) bus between the burst master and the DDR2 HP controller wrapper.
// master = command engine side, slave = controller side.
interface altmemddr_local_burst_master_if #(
  parameter int DATA_BITS = 64,
  parameter int ROW_BITS  = 13,
  parameter int BANK_BITS = 2,
  parameter int COL_BITS  = 9
);
  logic                   local_init_done;
  logic                   local_ready;
  logic                   local_rdata_valid;
  logic [DATA_BITS-1:0]   local_rdata;
  logic                   local_read_req;
  logic                   local_write_req;
  logic                   local_burstbegin;
  logic                   local_autopch_req;
  logic                   local_size;
  logic                   local_cs_addr;
  logic [ROW_BITS-1:0]    local_row_addr;
  logic [BANK_BITS-1:0]   local_bank_addr;
  logic [COL_BITS-1:0]    local_col_addr;
  logic [DATA_BITS-1:0]   local_wdata;
  logic [DATA_BITS/8-1:0] local_be;

  modport master (
    input  local_init_done, local_ready, local_rdata_valid, local_rdata,
    output local_read_req, local_write_req, local_burstbegin, local_autopch_req,
           local_size, local_cs_addr, local_row_addr, local_bank_addr,
           local_col_addr, local_wdata, local_be
  );

  modport slave (
    output local_init_done, local_ready, local_rdata_valid, local_rdata,
    input  local_read_req, local_write_req, local_burstbegin, local_autopch_req,
           local_size, local_cs_addr, local_row_addr, local_bank_addr,
           local_col_addr, local_wdata, local_be
  );
endinterface

// File: rtl/altmemddr_local_burst_master.sv
// Command engine for the DDR2 HP controller local interface: expands one read/write
// command into single-beat requests. Define LOCAL_MASTER_AUTOPCH_EN for auto-precharge on the last beat.
module altmemddr_local_burst_master #(
  parameter int DATA_BITS  = 64,
  parameter int ROW_BITS   = 13,
  parameter int BANK_BITS  = 2,
  parameter int COL_BITS   = 9,
  parameter int LEN_BITS   = 8,
  parameter int MAX_RD_OUT = 8
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic                                     cmd_write,
  input  logic [ROW_BITS+BANK_BITS+COL_BITS-1:0]   cmd_addr,
  input  logic [LEN_BITS-1:0]                      cmd_len,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [DATA_BITS-1:0]                     wr_data,
  input  logic [DATA_BITS/8-1:0]                   wr_be,
  output logic                                     rd_valid,
  output logic [DATA_BITS-1:0]                     rd_data,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     rd_err,
  altmemddr_local_burst_master_if.master           local_if
);
  localparam int ADDR_W = ROW_BITS + BANK_BITS + COL_BITS;
  localparam int REM_W  = LEN_BITS + 1;
  localparam int RD_W   = $clog2(MAX_RD_OUT) + 1;
  localparam logic [RD_W-1:0] RD_MAX = RD_W'(MAX_RD_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic                   req_pend_q, req_pend_d;
  logic                   req_write_q, req_write_d;
  logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [DATA_BITS-1:0]   req_data_q, req_data_d;
  logic [DATA_BITS/8-1:0] req_be_q, req_be_d;
  logic [RD_W-1:0]        rd_out_q, rd_out_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   rd_err_q, rd_err_d;

  logic            cmd_fire, slot_free, load, req_accept, issue_end, drain_end, unexpected;
  logic [RD_W-1:0] rd_sum;

  // A pending read not yet taken by the controller already counts against the read budget.
  always_comb begin
    cmd_fire   = cmd_ready && cmd_valid;
    slot_free  = (state_q == ISSUE) && (rem_q != '0) && (!req_pend_q || local_if.local_ready);
    rd_sum     = rd_out_q + RD_W'(req_pend_q && !req_write_q);
    load       = slot_free && (write_q ? wr_valid : (rd_sum < RD_MAX));
    req_accept = req_pend_q && local_if.local_ready;
    issue_end  = (rem_q == '0) && (!req_pend_q || local_if.local_ready);
    drain_end  = write_q || (rd_out_q == '0);
    unexpected = local_if.local_rdata_valid && (rd_out_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire)  state_d = ISSUE;
      ISSUE:   if (issue_end) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = reset_n && (state_q == IDLE) && local_if.local_init_done;
    wr_ready  = slot_free && write_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DRAIN) && drain_end;
  end

  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_pend_d  = req_pend_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_be_d    = req_be_q;
    if (cmd_fire) begin
      write_d = cmd_write;
      addr_d  = cmd_addr;
      rem_d   = (cmd_len == '0) ? {1'b1, {LEN_BITS{1'b0}}} : {1'b0, cmd_len};
    end
    if (load) begin
      req_pend_d  = 1'b1;
      req_write_d = write_q;
      req_addr_d  = addr_q;
      req_data_d  = write_q ? wr_data : '0;
      req_be_d    = write_q ? wr_be : '0;
      addr_d      = addr_q + ADDR_W'(1);
      rem_d       = rem_q - REM_W'(1);
    end else if (req_accept) begin
      req_pend_d = 1'b0;
    end
    rd_out_d   = rd_out_q + RD_W'(req_accept && !req_write_q)
                          - RD_W'(local_if.local_rdata_valid && !unexpected);
    rd_err_d   = rd_err_q || unexpected;
    rd_valid_d = local_if.local_rdata_valid;
    rd_data_d  = local_if.local_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      req_pend_q  <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_be_q    <= '0;
      rd_out_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      req_pend_q  <= req_pend_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_be_q    <= req_be_d;
      rd_out_q    <= rd_out_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

  assign local_if.local_read_req   = req_pend_q && !req_write_q;
  assign local_if.local_write_req  = req_pend_q && req_write_q;
  assign local_if.local_burstbegin = req_pend_q;
  assign local_if.local_size       = 1'b1;
  assign local_if.local_cs_addr    = 1'b0;
  assign local_if.local_row_addr   = req_addr_q[ADDR_W-1 -: ROW_BITS];
  assign local_if.local_bank_addr  = req_addr_q[COL_BITS +: BANK_BITS];
  assign local_if.local_col_addr   = req_addr_q[COL_BITS-1:0];
  assign local_if.local_wdata      = req_data_q;
  assign local_if.local_be         = req_be_q;

`ifdef LOCAL_MASTER_AUTOPCH_EN
  logic req_last_q, req_last_d;

  always_comb begin
    req_last_d = req_last_q;
    if (load) req_last_d = (rem_q == REM_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) req_last_q <= 1'b0;
    else          req_last_q <= req_last_d;
  end

  assign local_if.local_autopch_req = req_pend_q && req_last_q;
`else
  assign local_if.local_autopch_req = 1'b0;
`endif
endmodule

// File: tb/tb_altmemddr_local_burst_master.sv
// Directed bench for altmemddr_local_burst_master with a simple controller/memory responder.
module tb_altmemddr_local_burst_master;
  localparam int DW = 64, RB = 13, BB = 2, CB = 9, LB = 8, AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_valid, cmd_write, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LB-1:0] cmd_len;
  logic          wr_valid, wr_ready, rd_valid, busy, done, rd_err;
  logic [DW-1:0] wr_data, rd_data;
  logic [7:0]    wr_be;

  altmemddr_local_burst_master_if #(.DATA_BITS(DW), .ROW_BITS(RB), .BANK_BITS(BB), .COL_BITS(CB)) lif();

  altmemddr_local_burst_master #(
    .DATA_BITS(DW), .ROW_BITS(RB), .BANK_BITS(BB), .COL_BITS(CB), .LEN_BITS(LB), .MAX_RD_OUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done), .rd_err(rd_err),
    .local_if(lif)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; logic ap; } req_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  req_t wlog[$], rlog[$];
  ret_t retq[$];
  logic [DW-1:0] rdv[$];
  logic [DW-1:0] mem [int unsigned];
  int rdv_cyc = 0, done_cyc = 0, done_cnt = 0, done_base = 0, acc_cyc = 0;
  int outstanding = 0, max_out = 0, hold_err = 0, stall_cnt = 0, ap_seen = 0;
  int lat = 1;
  logic spur = 1'b0;
  logic [DW-1:0] spur_data = '0;
  logic prev_stall = 1'b0, prev_w = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {40'hC0DE000000, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and memory model: requests are taken at the edge ending a cycle with req & ready.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic          rq;
    a  = {lif.local_row_addr, lif.local_bank_addr, lif.local_col_addr};
    rq = lif.local_read_req || lif.local_write_req;
    if (lif.local_autopch_req) ap_seen++;
    if (prev_stall && (!rq || a != prev_addr || lif.local_wdata != prev_data || lif.local_write_req != prev_w))
      hold_err++;
    prev_stall = rq && !lif.local_ready;
    if (prev_stall) stall_cnt++;
    prev_addr = a; prev_data = lif.local_wdata; prev_w = lif.local_write_req;
    if (lif.local_ready && lif.local_write_req) begin
      mem[a] = lif.local_wdata;
      wlog.push_back('{a, lif.local_wdata, cyc, lif.local_autopch_req});
    end
    if (lif.local_ready && lif.local_read_req) begin
      rlog.push_back('{a, '0, cyc, lif.local_autopch_req});
      retq.push_back('{cyc + lat, mem.exists(a) ? mem[a] : pat(a)});
      outstanding++;
    end
    if (lif.local_rdata_valid && outstanding > 0) outstanding--;
    if (outstanding > max_out) max_out = outstanding;
    if (rd_valid) begin rdv.push_back(rd_data); rdv_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  // Read-data responder with fixed latency plus an injectable spurious beat.
  initial begin
    lif.local_rdata_valid = 1'b0;
    lif.local_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (retq.size() > 0 && retq[0].due <= cyc) begin
        lif.local_rdata_valid = 1'b1;
        lif.local_rdata = retq[0].data;
        void'(retq.pop_front());
      end else if (spur) begin
        lif.local_rdata_valid = 1'b1;
        lif.local_rdata = spur_data;
      end else begin
        lif.local_rdata_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LB-1:0] l);
    int k;
    k = 0;
    done_base = done_cnt;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin step(); @(negedge clk); k++; end
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] base, input int stall_at);
    int   wi, c;
    logic took;
    wi = 0; c = 0;
    while (wi < n && c < 300) begin
      lif.local_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      wr_valid = 1'b1; wr_data = base + DW'(wi);
      @(negedge clk); took = wr_ready;
      step();
      if (took) wi++;
      c++;
    end
    wr_valid = 1'b0;
    lif.local_ready = 1'b1;
    chk("wr_feed_count", wi, n);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt == done_base && k < budget) begin step(); k++; end
    chk(tag, done_cnt - done_base, 1);
  endtask

  initial begin
    logic [2:0] ap_exp;
    int errs;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = 8'hFF;
    lif.local_init_done = 1'b1; lif.local_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", {cmd_ready, wr_ready, rd_valid, busy, done, rd_err, lif.local_read_req,
        lif.local_write_req, lif.local_burstbegin, lif.local_autopch_req, lif.local_size,
        lif.local_cs_addr}, 12'b000000000010);
    chk("reset_bus", {lif.local_row_addr, lif.local_bank_addr, lif.local_col_addr, lif.local_wdata[31:0], rd_data[31:0]}, 0);
    step();
    reset_n = 1'b1;
    lif.local_init_done = 1'b0;
    @(negedge clk);
    chk("rdy_no_init", cmd_ready, 0);
    step();
    lif.local_init_done = 1'b1;
    @(negedge clk);
    chk("rdy_idle", cmd_ready, 1);
    step();

    // Write len=4 at 0x10, data 1..4
    wlog.delete();
    send_cmd(1'b1, 24'h000010, 8'd4);
    feed(4, 64'd1, -1);
    wait_done(50, "wr4_done");
    chk("wr4_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("wr4_addr", wlog[i].addr, 64'h10 + 64'(i));
        chk("wr4_data", wlog[i].data, 64'(i + 1));
        chk("wr4_cyc", wlog[i].cyc, wlog[0].cyc + i);
      end
      chk("wr4_first_lat", wlog[0].cyc, acc_cyc + 2);
      chk("wr4_done_cyc", done_cyc, wlog[3].cyc + 1);
    end
    chk("wr4_busy_after", busy, 0);

    // Read back len=4, latency 3
    lat = 3; rdv.delete(); rlog.delete();
    send_cmd(1'b0, 24'h000010, 8'd4);
    wait_done(100, "rd4_done");
    chk("rd4_count", rdv.size(), 4);
    if (rdv.size() == 4 && rlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rd4_data", rdv[i], 64'(i + 1));
      chk("rd4_first_lat", rlog[0].cyc, acc_cyc + 2);
      chk("rd4_rdv_lag", rdv_cyc, rlog[3].cyc + 4);
      chk("rd4_done_cyc", done_cyc, rdv_cyc);
    end

    // Backpressure: local_ready low 3 cycles mid-burst
    wlog.delete(); stall_cnt = 0; hold_err = 0;
    send_cmd(1'b1, 24'h000100, 8'd6);
    feed(6, 64'hA0, 2);
    wait_done(50, "bp_done");
    chk("bp_count", wlog.size(), 6);
    if (wlog.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("bp_addr", wlog[i].addr, 64'h100 + 64'(i));
        chk("bp_data", wlog[i].data, 64'hA0 + 64'(i));
      end
    chk("bp_stall_seen", stall_cnt, 3);
    chk("bp_hold", hold_err, 0);

    // Address wrap
    lat = 2; rlog.delete(); rdv.delete();
    send_cmd(1'b0, 24'hFFFFFF, 8'd2);
    wait_done(50, "wrap_done");
    chk("wrap_count", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("wrap_row0", rlog[0].addr[23:11], 13'h1FFF);
      chk("wrap_bank0", rlog[0].addr[10:9], 2'h3);
      chk("wrap_col0", rlog[0].addr[8:0], 9'h1FF);
      chk("wrap_addr1", rlog[1].addr, 0);
    end
    chk("wrap_rdv", rdv.size(), 2);

    // Outstanding limit: 256 beats, latency 20
    lat = 20; max_out = 0; rlog.delete(); rdv.delete();
    send_cmd(1'b0, 24'h002000, 8'd0);
    wait_done(3000, "lim_done");
    chk("lim_max_out", max_out, 8);
    chk("lim_req_count", rlog.size(), 256);
    chk("lim_rdv_count", rdv.size(), 256);
    errs = 0;
    for (int i = 0; i < rdv.size(); i++)
      if (rdv[i] !== pat(24'h002000 + 24'(i))) errs++;
    chk("lim_data", errs, 0);
    chk("lim_done_cyc", done_cyc, rdv_cyc);
    step();

    // Spurious read data in IDLE
    spur = 1'b1; spur_data = 64'h5A5A_1234;
    step();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_rd_valid", rd_valid, 1);
    chk("spur_rd_data", rd_data, 64'h5A5A_1234);
    chk("spur_rd_err", rd_err, 1);
    step();
    @(negedge clk);
    chk("spur_rd_valid_off", rd_valid, 0);
    chk("spur_err_sticky", rd_err, 1);
    step();

    // Auto-precharge on the final request only
    wlog.delete(); lat = 1;
`ifdef LOCAL_MASTER_AUTOPCH_EN
    ap_exp = 3'b100;
`else
    ap_exp = 3'b000;
    chk("ap_never", ap_seen, 0);
`endif
    send_cmd(1'b1, 24'h000200, 8'd3);
    feed(3, 64'h77, -1);
    wait_done(50, "ap_done");
    chk("ap_count", wlog.size(), 3);
    if (wlog.size() == 3)
      for (int i = 0; i < 3; i++) chk("ap_flag", wlog[i].ap, ap_exp[i]);

    // Reset mid-write
    send_cmd(1'b1, 24'h000300, 8'd8);
    feed(3, 64'h300, -1);
    @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    step();
    reset_n = 1'b0; wr_valid = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mid_outs", {cmd_ready, wr_ready, rd_valid, busy, done, rd_err, lif.local_read_req,
        lif.local_write_req, lif.local_burstbegin, lif.local_autopch_req, lif.local_size,
        lif.local_cs_addr}, 12'b000000000010);
    chk("rst_mid_wdata", lif.local_wdata, 0);
    step();
    reset_n = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", {cmd_ready, busy, rd_err}, 3'b100);
    step();

    // Post-reset read of earlier written beat
    lat = 1; rdv.delete();
    send_cmd(1'b0, 24'h000011, 8'd1);
    wait_done(50, "post_done");
    chk("post_rdv_count", rdv.size(), 1);
    if (rdv.size() == 1) chk("post_data", rdv[0], 64'd2);
    chk("post_rd_err", rd_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
